// File: rtl/strokie_pkg.sv
// Shared types and constants for the strokie FPU vector sequencer.
// Holds the opcode/mode encodings, the driver FSM state type, the test-vector
// record and the default 16-entry vector table.
package strokie_pkg;

    // FPU operation codes
    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_MUL = 3'b010;
    localparam logic [2:0] OP_DIV = 3'b011;

    // Precision select
    localparam logic MODE_HALF   = 1'b0;
    localparam logic MODE_SINGLE = 1'b1;

    // Rounding select
    localparam logic RND_NEAREST = 1'b0;
    localparam logic RND_ZERO    = 1'b1;

    // Physical depth of the vector table and of the result buffer
    localparam int unsigned VEC_DEPTH = 16;

    typedef enum logic [2:0] {
        StIdle,
        StIssue,
        StWait,
        StStore,
        StDone
    } state_e;

    typedef struct packed {
        logic [31:0] op_a;
        logic [31:0] op_b;
        logic [2:0]  op_code;
        logic        mode_fp;
        logic        round_mode;
    } vec_t;

    function automatic vec_t mk_vec(input logic [31:0] a, input logic [31:0] b,
                                    input logic [2:0] op, input logic mode,
                                    input logic rnd);
        vec_t v;
        v.op_a       = a;
        v.op_b       = b;
        v.op_code    = op;
        v.mode_fp    = mode;
        v.round_mode = rnd;
        return v;
    endfunction

    // Default table; half-precision operands sit in the low 16 bits.
    function automatic vec_t default_vec(input logic [3:0] idx);
        vec_t v;
        case (idx)
            4'd0:  v = mk_vec(32'h0000_0064, 32'h0000_0047, OP_ADD, MODE_HALF,   RND_NEAREST);
            4'd1:  v = mk_vec(32'h0000_3C00, 32'h0000_4000, OP_ADD, MODE_HALF,   RND_NEAREST);
            4'd2:  v = mk_vec(32'h0000_4200, 32'h0000_3C00, OP_SUB, MODE_HALF,   RND_NEAREST);
            4'd3:  v = mk_vec(32'h0000_4000, 32'h0000_4200, OP_MUL, MODE_HALF,   RND_NEAREST);
            4'd4:  v = mk_vec(32'h3F80_0000, 32'h4000_0000, OP_ADD, MODE_SINGLE, RND_NEAREST);
            4'd5:  v = mk_vec(32'h4040_0000, 32'h3F80_0000, OP_SUB, MODE_SINGLE, RND_NEAREST);
            4'd6:  v = mk_vec(32'h4000_0000, 32'h4040_0000, OP_MUL, MODE_SINGLE, RND_NEAREST);
            4'd7:  v = mk_vec(32'h40C0_0000, 32'h4000_0000, OP_DIV, MODE_SINGLE, RND_NEAREST);
            4'd8:  v = mk_vec(32'h0000_4600, 32'h0000_4000, OP_DIV, MODE_HALF,   RND_NEAREST);
            // Overflow, divide-by-zero, underflow and NaN corner cases
            4'd9:  v = mk_vec(32'h0000_7BFF, 32'h0000_7BFF, OP_ADD, MODE_HALF,   RND_ZERO);
            4'd10: v = mk_vec(32'h7F7F_FFFF, 32'h4000_0000, OP_MUL, MODE_SINGLE, RND_NEAREST);
            4'd11: v = mk_vec(32'h0080_0000, 32'h3F00_0000, OP_MUL, MODE_SINGLE, RND_ZERO);
            4'd12: v = mk_vec(32'h0000_3C00, 32'h0000_0000, OP_DIV, MODE_HALF,   RND_NEAREST);
            4'd13: v = mk_vec(32'h7FC0_0000, 32'h3F80_0000, OP_ADD, MODE_SINGLE, RND_NEAREST);
            4'd14: v = mk_vec(32'h0000_BC00, 32'h0000_3C00, OP_ADD, MODE_HALF,   RND_NEAREST);
            default: v = mk_vec(32'hBF80_0000, 32'hBF80_0000, OP_MUL, MODE_SINGLE, RND_NEAREST);
        endcase
        return v;
    endfunction

endpackage

// File: rtl/strokie_vec_rom.sv
// Combinational lookup into the default vector table. The driver registers
// the looked-up entry at its FPU outputs.
module strokie_vec_rom
    import strokie_pkg::*;
(
    input  logic [3:0] idx,
    output vec_t       vec
);

    // Pure table decode
    always_comb begin
        vec = default_vec(idx);
    end

endmodule

// File: rtl/strokie_seq_driver.sv
// Vector sequencer for one strokie FPU: issues N_VEC table operations through
// the START/VALID handshake, buffers the results, ORs the status flags, aborts
// on a hung FPU and cycles the buffered results onto the LEDs.
module strokie_seq_driver
    import strokie_pkg::*;
#(
    parameter int unsigned N_VEC   = 4,
    parameter int unsigned TIMEOUT = 64,
    parameter int unsigned DWELL   = 50_000_000,
    parameter int unsigned LED_W   = 8
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             GO,
    input  logic [1:0]       LED_SEL,
    output logic [31:0]      FPU_OP_A,
    output logic [31:0]      FPU_OP_B,
    output logic [2:0]       FPU_OP_CODE,
    output logic             FPU_MODE_FP,
    output logic             FPU_ROUND_MODE,
    output logic             FPU_START,
    input  logic [31:0]      FPU_RESULT,
    input  logic             FPU_VALID,
    input  logic [4:0]       FPU_FLAGS,
    output logic [LED_W-1:0] leds,
    output logic             BUSY,
    output logic             DONE,
    output logic             ERR,
    output logic [4:0]       FLAGS_ACC
);

    localparam logic [3:0]  LAST_IDX  = 4'(N_VEC - 1);
    localparam logic [31:0] WAIT_LAST = 32'(TIMEOUT - 1);
    localparam logic [31:0] DWELL_LAST = 32'(DWELL - 1);
    localparam vec_t        RESET_VEC = default_vec(4'd0);

    state_e            state_q, state_d;
    logic [3:0]        idx_q, idx_d;
    logic [3:0]        disp_q, disp_d;
    logic [31:0]       wcnt_q, wcnt_d;
    logic [31:0]       dcnt_q, dcnt_d;
    logic              err_q, err_d;
    logic [4:0]        flags_q, flags_d;
    logic [31:0]       res_q [VEC_DEPTH];
    logic [31:0]       res_d [VEC_DEPTH];
    vec_t              rom_vec;
    vec_t              vec_q;
    logic              start_q;
    logic              busy_q;
    logic              done_q;
    logic [LED_W-1:0]  leds_q, leds_d;
    logic [31:0]       shown;
    logic [7:0]        sel_byte;

    // Table is addressed by the next index so the registered operands are
    // already valid in the ISSUE cycle and stay put through WAIT.
    strokie_vec_rom u_vec_rom (
        .idx (idx_d),
        .vec (rom_vec)
    );

    // Next-state logic: sequencing, timeout, result capture and display stepping
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        disp_d  = disp_q;
        wcnt_d  = wcnt_q;
        dcnt_d  = dcnt_q;
        err_d   = err_q;
        flags_d = flags_q;
        for (int i = 0; i < VEC_DEPTH; i++) begin
            res_d[i] = res_q[i];
        end

        unique case (state_q)
            StIdle, StDone: begin
                if (GO) begin
                    state_d = StIssue;
                    idx_d   = '0;
                    disp_d  = '0;
                    wcnt_d  = '0;
                    dcnt_d  = '0;
                    err_d   = 1'b0;
                    flags_d = '0;
                    for (int i = 0; i < VEC_DEPTH; i++) begin
                        res_d[i] = '0;
                    end
                end else if (state_q == StDone) begin
                    if (dcnt_q == DWELL_LAST) begin
                        dcnt_d = '0;
                        disp_d = (disp_q == LAST_IDX) ? 4'd0 : disp_q + 4'd1;
                    end else begin
                        dcnt_d = dcnt_q + 32'd1;
                    end
                end
            end
            StIssue: begin
                // VALID is deliberately not looked at here
                state_d = StWait;
                wcnt_d  = '0;
            end
            StWait: begin
                // A VALID on the limit cycle still counts as a completion
                if (FPU_VALID) begin
                    res_d[idx_q] = FPU_RESULT;
                    flags_d      = flags_q | FPU_FLAGS;
                    state_d      = StStore;
                end else if (wcnt_q == WAIT_LAST) begin
                    res_d[idx_q] = '0;
                    err_d        = 1'b1;
                    state_d      = StDone;
                    disp_d       = '0;
                    dcnt_d       = '0;
                end else begin
                    wcnt_d = wcnt_q + 32'd1;
                end
            end
            StStore: begin
                if (idx_q == LAST_IDX) begin
                    state_d = StDone;
                    disp_d  = '0;
                    dcnt_d  = '0;
                end else begin
                    idx_d   = idx_q + 4'd1;
                    state_d = StIssue;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // LED mux works on next-state values so the registered LEDs track DONE exactly
    always_comb begin
        shown    = res_d[disp_d];
        sel_byte = '0;
        unique case (LED_SEL)
            2'd0: sel_byte = shown[7:0];
            2'd1: sel_byte = shown[15:8];
            2'd2: sel_byte = shown[23:16];
            2'd3: sel_byte = shown[31:24];
            default: sel_byte = '0;
        endcase
        leds_d = (state_d == StDone) ? LED_W'(sel_byte) : '0;
    end

    // FSM, counters, result buffer and all registered outputs
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q <= StIdle;
            idx_q   <= '0;
            disp_q  <= '0;
            wcnt_q  <= '0;
            dcnt_q  <= '0;
            err_q   <= 1'b0;
            flags_q <= '0;
            for (int i = 0; i < VEC_DEPTH; i++) begin
                res_q[i] <= '0;
            end
            vec_q   <= RESET_VEC;
            start_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            leds_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            disp_q  <= disp_d;
            wcnt_q  <= wcnt_d;
            dcnt_q  <= dcnt_d;
            err_q   <= err_d;
            flags_q <= flags_d;
            for (int i = 0; i < VEC_DEPTH; i++) begin
                res_q[i] <= res_d[i];
            end
            vec_q   <= rom_vec;
            start_q <= (state_d == StIssue);
            busy_q  <= (state_d == StIssue) || (state_d == StWait) || (state_d == StStore);
            done_q  <= (state_d == StDone);
            leds_q  <= leds_d;
        end
    end

    assign FPU_OP_A       = vec_q.op_a;
    assign FPU_OP_B       = vec_q.op_b;
    assign FPU_OP_CODE    = vec_q.op_code;
    assign FPU_MODE_FP    = vec_q.mode_fp;
    assign FPU_ROUND_MODE = vec_q.round_mode;
    assign FPU_START      = start_q;
    assign BUSY           = busy_q;
    assign DONE           = done_q;
    assign ERR            = err_q;
    assign FLAGS_ACC      = flags_q;
    assign leds           = leds_q;

endmodule

// File: tb/tb_strokie_seq_driver.sv
// Directed bench for strokie_seq_driver with a small behavioural FPU model.
module tb_strokie_seq_driver;

    localparam int unsigned N_VEC   = 4;
    localparam int unsigned TIMEOUT = 16;
    localparam int unsigned DWELL   = 2;
    localparam int unsigned LED_W   = 8;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             go = 1'b0;
    logic [1:0]       led_sel = 2'd0;
    logic [31:0]      op_a, op_b;
    logic [2:0]       op_code;
    logic             mode_fp, round_mode;
    logic             fpu_start;
    logic             fpu_valid;
    logic [LED_W-1:0] leds;
    logic             busy, done, err;
    logic [4:0]       flags_acc;

    // FPU model state
    int          lat = 3;
    logic [4:0]  flag_tab [16];
    logic        m_clr = 1'b0;
    logic        spur = 1'b0;
    logic        m_valid = 1'b0;
    logic [31:0] m_result = '0;
    logic [4:0]  m_flags = '0;
    logic        pend = 1'b0;
    int          wc = 0;
    int          vcnt = 0;
    logic        fire;

    int start_cnt = 0;
    int checks = 0;
    int errors = 0;
    int n;
    int s0;

    always #5 clk = ~clk;

    strokie_seq_driver #(
        .N_VEC   (N_VEC),
        .TIMEOUT (TIMEOUT),
        .DWELL   (DWELL),
        .LED_W   (LED_W)
    ) u_dut (
        .CLK            (clk),
        .RESET          (rst_n),
        .GO             (go),
        .LED_SEL        (led_sel),
        .FPU_OP_A       (op_a),
        .FPU_OP_B       (op_b),
        .FPU_OP_CODE    (op_code),
        .FPU_MODE_FP    (mode_fp),
        .FPU_ROUND_MODE (round_mode),
        .FPU_START      (fpu_start),
        .FPU_RESULT     (m_result),
        .FPU_VALID      (fpu_valid),
        .FPU_FLAGS      (m_flags),
        .leds           (leds),
        .BUSY           (busy),
        .DONE           (done),
        .ERR            (err),
        .FLAGS_ACC      (flags_acc)
    );

    assign fpu_valid = m_valid | spur;
    // VALID is raised in the lat-th cycle after the START cycle; lat = 0 never answers
    assign fire = fpu_start ? (lat == 1) : (pend && lat != 0 && lat == wc);

    always @(posedge clk) begin
        m_valid <= 1'b0;
        if (fpu_start) begin
            pend <= 1'b1;
            wc   <= 2;
        end else if (pend) begin
            wc <= wc + 1;
        end
        if (fire) begin
            m_valid  <= 1'b1;
            m_result <= 32'hA000_0000 + 32'(vcnt);
            m_flags  <= flag_tab[vcnt[3:0]];
            pend     <= 1'b0;
        end
        if (m_clr) vcnt <= 0;
        else if (fire) vcnt <= vcnt + 1;
    end

    always @(posedge clk) begin
        if (fpu_start) start_cnt <= start_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int cyc);
        repeat (cyc) @(posedge clk);
        #1;
    endtask

    // Leaves the bench one step after the GO-sampling edge
    task automatic pulse_go();
        go = 1'b1;
        m_clr = 1'b1;
        step(1);
        go = 1'b0;
        m_clr = 1'b0;
    endtask

    task automatic wait_done(input int budget, output int cyc);
        cyc = 0;
        while (done !== 1'b1 && cyc < budget) begin
            step(1);
            cyc++;
        end
    endtask

    initial begin
        for (int i = 0; i < 16; i++) flag_tab[i] = 5'b0;

        // Reset values
        step(2);
        chk("rst_start", fpu_start, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_flags", flags_acc, 0);
        chk("rst_leds", leds, 0);
        chk("rst_op_a", op_a, 32'h0000_0064);
        chk("rst_op_b", op_b, 32'h0000_0047);
        chk("rst_op_code", op_code, 3'b000);
        chk("rst_mode", mode_fp, 0);
        rst_n = 1'b1;
        step(1);
        chk("idle_busy", busy, 0);

        // Normal run: L = 3, START every 5 cycles, DONE 20 cycles after GO
        s0 = start_cnt;
        pulse_go();
        chk("n_start0", fpu_start, 1);
        chk("n_busy", busy, 1);
        chk("n_leds_busy", leds, 0);
        step(1);
        chk("n_start0_drop", fpu_start, 0);
        for (int v = 1; v < 4; v++) begin
            step(4);
            chk($sformatf("n_start%0d", v), fpu_start, 1);
            step(1);
            chk($sformatf("n_start%0d_drop", v), fpu_start, 0);
        end
        step(3);
        chk("n_done_e19", done, 0);
        step(1);
        chk("n_done_e20", done, 1);
        chk("n_busy_done", busy, 0);
        chk("n_err", err, 0);
        chk("n_flags", flags_acc, 0);
        chk("n_start_count", 32'(start_cnt - s0), 4);
        // DWELL = 2: disp goes 0,0,1,1,2,2,3,3,0
        for (int i = 0; i < 9; i++) begin
            chk($sformatf("n_led%0d", i), leds, 32'((i / 2) % 4));
            step(1);
        end
        led_sel = 2'd3;
        step(1);
        chk("n_led_byte3", leds, 8'hA0);
        led_sel = 2'd0;

        // Flag accumulation
        flag_tab[1] = 5'b00001;
        flag_tab[3] = 5'b10000;
        pulse_go();
        chk("f_flags_clr", flags_acc, 0);
        chk("f_leds_off", leds, 0);
        chk("f_done_off", done, 0);
        wait_done(40, n);
        chk("f_len", 32'(n), 20);
        chk("f_flags", flags_acc, 5'b10001);
        flag_tab[1] = 5'b0;
        flag_tab[3] = 5'b0;

        // Asynchronous reset while in DONE
        led_sel = 2'd3;
        step(1);
        chk("d_leds_pre", leds, 8'hA0);
        #2 rst_n = 1'b0;
        #1;
        chk("d_rst_done", done, 0);
        chk("d_rst_flags", flags_acc, 0);
        chk("d_rst_leds", leds, 0);
        step(1);
        rst_n = 1'b1;
        led_sel = 2'd0;

        // Spurious VALID in ISSUE (carrying flags 10000) and GO while busy are ignored
        pulse_go();
        spur = 1'b1;
        step(1);
        spur = 1'b0;
        go = 1'b1;
        step(1);
        go = 1'b0;
        wait_done(40, n);
        chk("r_len", 32'(n + 2), 20);
        chk("r_flags", flags_acc, 0);
        chk("r_err", err, 0);
        step(2);
        chk("r_led_disp1", leds, 8'h01);

        // Reset during ISSUE drops START without a clock
        pulse_go();
        chk("i_start_pre", fpu_start, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("i_rst_start", fpu_start, 0);
        chk("i_rst_busy", busy, 0);
        chk("i_rst_op_a", op_a, 32'h0000_0064);
        step(1);
        rst_n = 1'b1;

        // Reset mid-WAIT; the model's late VALID lands while the FSM is idle
        flag_tab[0] = 5'b00100;
        pulse_go();
        step(1);
        #2 rst_n = 1'b0;
        #1;
        chk("w_rst_busy", busy, 0);
        step(1);
        rst_n = 1'b1;
        step(3);
        chk("w_late_busy", busy, 0);
        chk("w_late_done", done, 0);
        chk("w_late_flags", flags_acc, 0);
        flag_tab[0] = 5'b0;
        pulse_go();
        wait_done(40, n);
        chk("w_len", 32'(n), 20);
        chk("w_err", err, 0);
        step(2);
        chk("w_led_disp1", leds, 8'h01);

        // Timeout: no VALID ever, ERR and DONE on the 17th edge after START
        lat = 0;
        led_sel = 2'd3;
        s0 = start_cnt;
        pulse_go();
        step(16);
        chk("t_done_e16", done, 0);
        chk("t_err_e16", err, 0);
        step(1);
        chk("t_done_e17", done, 1);
        chk("t_err_e17", err, 1);
        chk("t_leds", leds, 0);
        step(4);
        chk("t_err_sticky", err, 1);
        chk("t_start_count", 32'(start_cnt - s0), 1);

        // A new GO clears ERR and runs normally
        lat = 3;
        led_sel = 2'd0;
        pulse_go();
        chk("t_err_clr", err, 0);
        wait_done(40, n);
        chk("t_rerun_len", 32'(n), 20);
        chk("t_rerun_err", err, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
